mc_datapath: RTL and testbench
==============================

# mc_datapath

Parametrised multicycle MIPS datapath. Successor to the single-cycle datapath: one unified memory port, non-architectural state registers (IR, MDR, A, B, ALUOut), a four-way ALU B-source, a three-way PC source, and a register file sized by parameter. It sits between the multicycle controller FSM and the unified instruction/data memory inside the multicycle MIPS top level.

## Interface
- N_REGS, 32: architectural register count, 8..32; register address width is $clog2(N_REGS)
- RESET_PC, 32'h0000_0000: PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pcen  in  1  PC write enable (controller supplies pcwrite | branch&zero)
- iord  in  1  adr source: 0 = PC, 1 = ALUOut
- irwrite  in  1  IR load enable
- regdst  in  1  write register: 0 = rt, 1 = rd
- memtoreg  in  1  write data: 0 = ALUOut, 1 = MDR
- regwrite  in  1  register file write enable
- alusrca  in  1  ALU A: 0 = PC, 1 = A
- alusrcb  in  2  ALU B: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2
- pcsrc  in  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reserved (holds PC)
- alucontrol  in  3  ALU operation
- zeroext  in  1  1 = zero-extend immediate (ori/andi), 0 = sign-extend
- readdata  in  32  memory read data
- zero  out  1  ALU result == 0, combinational
- op  out  6  IR[31:26]
- funct  out  6  IR[5:0]
- adr  out  32  memory address
- writedata  out  32  B register, memory store data

## Operation
- Fields from IR only: rs = IR[25:21], rt = IR[20:16], rd = IR[15:11], imm = IR[15:0], jaddr = IR[25:0].
- IR loads readdata when irwrite; MDR, A, B, ALUOut load every cycle unconditionally.
- A and B capture register file reads of rs/rt; ALUOut captures the ALU result.
- ALU: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 0 or 1). Other codes give 0. All arithmetic is 32-bit modulo; no overflow flag.
- Jump target = {PC[31:28], jaddr, 2'b00}. PC[31:28] is taken from the current PC, which already holds PC+4 after fetch.
- PC loads the selected next PC only when pcen. pcsrc = 11 with pcen leaves PC unchanged.
- Register file:
  - two combinational reads and one write on the clock edge when regwrite.
  - Register 0 always reads 0; writes to it are dropped.
  - Addresses >= N_REGS read 0 and writes to them are dropped.
  - A write and a read of the same register in one cycle return the old value (no bypass).

## Timing
- Reset: PC = RESET_PC; IR, MDR, A, B, ALUOut = 0; all registers in the register file = 0. Outputs follow: adr = RESET_PC when iord = 0, op = funct = 0, writedata = 0.
- Reset wins over every enable in the same cycle. Reset asserted mid-instruction discards all in-flight state.
- adr, zero, op and funct are combinational from current state and controls. Memory read data must be valid in the same cycle as adr.
- Datapath latency is exactly one cycle per state register. Fetch issued in cycle n appears in IR at the n+1 edge, and register operands appear in A/B one cycle after that.

## Configuration
- MC_JAL_EN defined: regdst widens to 2 bits (00 rt, 01 rd, 10 register 31) and memtoreg widens to 2 bits (00 ALUOut, 01 MDR, 10 PC). Together these let jal write the return address. If N_REGS < 32, the register-31 write is dropped.
- MC_JAL_EN undefined: both controls are 1 bit as listed under Interface; there is no link path.

## Structure
- Package mc_pkg holds the following:
  - alusrcb_t, pcsrc_t and alucontrol_t enums with the encodings above
  - the RESET_PC default
  - the jal register index 31
- Sub-module mc_regfile, parameterised by N_REGS. The ALU, extender and muxes stay inline, or use the existing alu, mux2 and flopr cells.

## Test plan
- Reset with RESET_PC = 32'h0000_0040 -> PC = 0x40, adr = 0x40, and all state registers read 0.
- Fetch: readdata = 32'h2008_0005 (addi $8,$0,5), irwrite = 1, alusrca = 0, alusrcb = 01, pcsrc = 00, pcen = 1 -> next cycle IR = 0x20080005, PC = 0x44. Then an execute plus writeback -> $8 = 5.
- ori with imm 0x8001 and zeroext = 1 -> result 0x0000_8001. With zeroext = 0 an add of the same immediate gives 0xFFFF_8001.
- beq: A = B = 7, alucontrol = 110 -> zero = 1. Branch target from ALUOut = PC + (imm << 2) is loaded with pcsrc = 01.
- j with jaddr = 26'h000_0010 and PC = 0x4000_0004 -> PC = 0x4000_0040.
- N_REGS = 8: write 0xDEAD to register 12 -> reading register 12 returns 0. Write 0xDEAD to register 0 -> reading register 0 returns 0. With MC_JAL_EN and N_REGS = 32, a jal link write gives $31 = PC+4.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS datapath.
package mc_pkg;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SL2 = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alucontrol_t;

    localparam logic [31:0] MC_RESET_PC = 32'h0000_0000;
    localparam logic [4:0]  JAL_REG     = 5'd31;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational reads, one synchronous write, no bypass.
// Register 0 and any address >= N_REGS read as zero and ignore writes.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int N_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    logic [31:0] rf_q [N_REGS];
    logic [31:0] rf_d [N_REGS];

    logic ra1_ok;
    logic ra2_ok;
    logic wa_ok;

    always_comb begin
        ra1_ok = (ra1 != 5'd0) && (32'(ra1) < N_REGS);
        ra2_ok = (ra2 != 5'd0) && (32'(ra2) < N_REGS);
        wa_ok  = (wa != 5'd0) && (32'(wa) < N_REGS);
        rd1 = '0;
        rd2 = '0;
        if (ra1_ok) rd1 = rf_q[ra1[AW-1:0]];
        if (ra2_ok) rd2 = rf_q[ra2[AW-1:0]];
    end

    always_comb begin
        rf_d = rf_q;
        if (we && wa_ok) rf_d[wa[AW-1:0]] = wd;
    end

    always_ff @(posedge clk) begin
        if (reset) rf_q <= '{default: '0};
        else       rf_q <= rf_d;
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath with unified memory port and IR/MDR/A/B/ALUOut.
// Define MC_JAL_EN to widen regdst/memtoreg for the jal link path.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int          N_REGS   = 32,
    parameter logic [31:0] RESET_PC = MC_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        iord,
    input  logic        irwrite,
`ifdef MC_JAL_EN
    input  logic [1:0]  regdst,
    input  logic [1:0]  memtoreg,
`else
    input  logic        regdst,
    input  logic        memtoreg,
`endif
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic        zeroext,
    input  logic [31:0] readdata,
    output logic        zero,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] adr,
    output logic [31:0] writedata
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;

    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] imm_ext;
    logic [31:0] srca, srcb;
    logic [31:0] alu_y;
    logic [31:0] pc_next;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rf_rd1, rf_rd2;

    always_comb begin
        rs    = ir_q[25:21];
        rt    = ir_q[20:16];
        rd    = ir_q[15:11];
        imm   = ir_q[15:0];
        jaddr = ir_q[25:0];
        op    = ir_q[31:26];
        funct = ir_q[5:0];
        imm_ext = zeroext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    end

    always_comb begin
        srca = alusrca ? a_q : pc_q;
        srcb = b_q;
        case (alusrcb_t'(alusrcb))
            SRCB_B:       srcb = b_q;
            SRCB_FOUR:    srcb = 32'd4;
            SRCB_IMM:     srcb = imm_ext;
            SRCB_IMM_SL2: srcb = {imm_ext[29:0], 2'b00};
            default:      srcb = b_q;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alucontrol_t'(alucontrol))
            ALU_AND: alu_y = srca & srcb;
            ALU_OR:  alu_y = srca | srcb;
            ALU_ADD: alu_y = srca + srcb;
            ALU_SUB: alu_y = srca - srcb;
            ALU_SLT: alu_y = {31'd0, $signed(srca) < $signed(srcb)};
            default: alu_y = '0;
        endcase
        zero = (alu_y == 32'd0);
    end

    // The jump region bits come from the already-incremented PC.
    always_comb begin
        pc_next = pc_q;
        case (pcsrc_t'(pcsrc))
            PCSRC_ALU:    pc_next = alu_y;
            PCSRC_ALUOUT: pc_next = aluout_q;
            PCSRC_JUMP:   pc_next = {pc_q[31:28], jaddr, 2'b00};
            PCSRC_HOLD:   pc_next = pc_q;
            default:      pc_next = pc_q;
        endcase
    end

    always_comb begin
`ifdef MC_JAL_EN
        case (regdst)
            2'b00:   wr_addr = rt;
            2'b01:   wr_addr = rd;
            2'b10:   wr_addr = JAL_REG;
            default: wr_addr = rt;
        endcase
        case (memtoreg)
            2'b00:   wr_data = aluout_q;
            2'b01:   wr_data = mdr_q;
            2'b10:   wr_data = pc_q;
            default: wr_data = aluout_q;
        endcase
`else
        wr_addr = regdst ? rd : rt;
        wr_data = memtoreg ? mdr_q : aluout_q;
`endif
    end

    mc_regfile #(
        .N_REGS (N_REGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (regwrite),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wr_addr),
        .wd    (wr_data),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2)
    );

    always_comb begin
        pc_d     = pcen ? pc_next : pc_q;
        ir_d     = irwrite ? readdata : ir_q;
        mdr_d    = readdata;
        a_d      = rf_rd1;
        b_d      = rf_rd2;
        aluout_d = alu_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    always_comb begin
        adr       = iord ? aluout_q : pc_q;
        writedata = b_q;
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Testbench for mc_datapath: a 32-register instance and an 8-register
// instance driven by the same controls.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcen, iord, irwrite, regwrite, alusrca, zeroext;
`ifdef MC_JAL_EN
    logic [1:0]  regdst, memtoreg;
`else
    logic        regdst, memtoreg;
`endif
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] readdata;

    logic        zero, zero8;
    logic [5:0]  op, op8, funct, funct8;
    logic [31:0] adr, adr8, writedata, writedata8;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mc_datapath #(.N_REGS(32), .RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .zeroext(zeroext),
        .readdata(readdata), .zero(zero), .op(op), .funct(funct),
        .adr(adr), .writedata(writedata)
    );

    mc_datapath #(.N_REGS(8)) dut8 (
        .clk(clk), .reset(reset), .pcen(pcen), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .zeroext(zeroext),
        .readdata(readdata), .zero(zero8), .op(op8), .funct(funct8),
        .adr(adr8), .writedata(writedata8)
    );

    typedef struct {
        string       name;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        asrc;
        logic [1:0]  bsrc;
        logic [2:0]  ctl;
        logic        zext;
        logic [31:0] exp_y;
        logic        exp_z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        readdata = w;
        irwrite  = 1'b1;
        step();
        irwrite  = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({6'h00, 5'd0, r, 16'h0000});
        readdata = v;
        step();
        regdst   = '0;
        memtoreg = 1;
        regwrite = 1'b1;
        step();
        regwrite = 1'b0;
        memtoreg = '0;
    endtask

    task automatic read_reg(input logic [4:0] r);
        load_ir({6'h00, 5'd0, r, 16'h0000});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"add",      5'd9,  5'd10, 16'h0000, 1, 2'b00, 3'b010, 0, 32'd14,        0};
        vecs[1]  = '{"sub_eq",   5'd9,  5'd10, 16'h0000, 1, 2'b00, 3'b110, 0, 32'd0,         1};
        vecs[2]  = '{"and",      5'd11, 5'd12, 16'h0000, 1, 2'b00, 3'b000, 0, 32'd0,         1};
        vecs[3]  = '{"or",       5'd11, 5'd12, 16'h0000, 1, 2'b00, 3'b001, 0, 32'hFFFF_FFF3, 0};
        vecs[4]  = '{"slt_t",    5'd11, 5'd12, 16'h0000, 1, 2'b00, 3'b111, 0, 32'd1,         0};
        vecs[5]  = '{"slt_f",    5'd12, 5'd11, 16'h0000, 1, 2'b00, 3'b111, 0, 32'd0,         1};
        vecs[6]  = '{"ori_zx",   5'd0,  5'd0,  16'h8001, 1, 2'b10, 3'b001, 1, 32'h0000_8001, 0};
        vecs[7]  = '{"add_sx",   5'd0,  5'd0,  16'h8001, 1, 2'b10, 3'b010, 0, 32'hFFFF_8001, 0};
        vecs[8]  = '{"andi_zx",  5'd11, 5'd0,  16'h8001, 1, 2'b10, 3'b000, 1, 32'h0000_8000, 0};
        vecs[9]  = '{"imm_sl2",  5'd9,  5'd0,  16'h0004, 1, 2'b11, 3'b010, 0, 32'd23,        0};
        vecs[10] = '{"plus4",    5'd9,  5'd0,  16'h0000, 1, 2'b01, 3'b010, 0, 32'd11,        0};
        vecs[11] = '{"bad_op",   5'd9,  5'd10, 16'h0000, 1, 2'b00, 3'b011, 0, 32'd0,         1};

        reset = 1'b1; pcen = 0; iord = 0; irwrite = 0; regwrite = 0;
        regdst = '0; memtoreg = '0; alusrca = 0; alusrcb = 2'b01;
        pcsrc = 2'b00; alucontrol = 3'b010; zeroext = 0;
        readdata = 32'h0;
        step();
        step();
        chk("rst_pc", adr, 32'h40);
        chk("rst_pc8", adr8, 32'h0);
        chk("rst_op", {26'd0, op}, 32'd0);
        chk("rst_funct", {26'd0, funct}, 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        iord = 1; #1;
        chk("rst_aluout", adr, 32'd0);
        iord = 0;
        reset = 1'b0;

        readdata = 32'h2008_0005;
        irwrite = 1; pcen = 1;
        step();
        irwrite = 0; pcen = 0;
        chk("fetch_op", {26'd0, op}, 32'h08);
        chk("fetch_funct", {26'd0, funct}, 32'h05);
        chk("fetch_pc", adr, 32'h44);
        step();
        alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; zeroext = 0;
        step();
        iord = 1; #1;
        chk("addi_exec", adr, 32'd5);
        iord = 0;
        regdst = '0; memtoreg = '0; regwrite = 1;
        step();
        regwrite = 0;
        step();
        chk("addi_wb", writedata, 32'd5);
        chk("addi_wb8", writedata8, 32'd0);

        write_reg(5'd9, 32'd7);
        write_reg(5'd10, 32'd7);
        write_reg(5'd11, 32'hFFFF_FFF0);
        write_reg(5'd12, 32'd3);

        for (int i = 0; i < 12; i++) begin
            load_ir({6'h00, vecs[i].rs, vecs[i].rt, vecs[i].imm});
            step();
            alusrca = vecs[i].asrc;
            alusrcb = vecs[i].bsrc;
            alucontrol = vecs[i].ctl;
            zeroext = vecs[i].zext;
            #1;
            chk({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_z});
            exp_q.push_back(vecs[i].exp_y);
            step();
            iord = 1; #1;
            chk(vecs[i].name, adr, exp_q.pop_front());
            iord = 0;
        end
        zeroext = 0;

        load_ir({6'h04, 5'd9, 5'd10, 16'h0003});
        step();
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b110; #1;
        chk("beq_zero", {31'd0, zero}, 32'd1);
        alusrca = 0; alusrcb = 2'b11; alucontrol = 3'b010;
        step();
        pcsrc = 2'b01; pcen = 1;
        step();
        pcen = 0;
        chk("beq_pc", adr, 32'h50);
        chk("beq_pc8", adr8, 32'h10);

        write_reg(5'd13, 32'h4000_0004);
        load_ir({6'h00, 5'd13, 5'd0, 16'h0000});
        step();
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b010;
        pcsrc = 2'b00; pcen = 1;
        step();
        pcen = 0;
        chk("pc_from_alu", adr, 32'h4000_0004);
        chk("pc_from_alu8", adr8, 32'h0);
        load_ir({6'h02, 26'h000_0010});
        pcsrc = 2'b10; pcen = 1;
        step();
        pcen = 0;
        chk("jump_pc", adr, 32'h4000_0040);
        chk("jump_pc8", adr8, 32'h0000_0040);
        pcsrc = 2'b11; pcen = 1;
        step();
        pcen = 0;
        chk("pc_hold", adr, 32'h4000_0040);

        write_reg(5'd12, 32'hDEAD);
        read_reg(5'd12);
        chk("r12_n32", writedata, 32'hDEAD);
        chk("r12_n8", writedata8, 32'h0);
        write_reg(5'd0, 32'hDEAD);
        read_reg(5'd0);
        chk("r0_n32", writedata, 32'h0);
        chk("r0_n8", writedata8, 32'h0);
        write_reg(5'd7, 32'hBEEF);
        read_reg(5'd7);
        chk("r7_n8", writedata8, 32'hBEEF);

        load_ir({6'h00, 5'd0, 5'd9, 16'h0000});
        readdata = 32'h123;
        step();
        regdst = '0; memtoreg = 1; regwrite = 1;
        step();
        regwrite = 0; memtoreg = '0;
        chk("no_bypass", writedata, 32'd7);
        step();
        chk("after_write", writedata, 32'h123);

        reset = 1; irwrite = 1; pcen = 1; pcsrc = 2'b00;
        regwrite = 1; memtoreg = 1; readdata = 32'hFFFF_FFFF;
        step();
        reset = 0; irwrite = 0; pcen = 0; regwrite = 0; memtoreg = '0;
        chk("mid_rst_pc", adr, 32'h40);
        chk("mid_rst_op", {26'd0, op}, 32'd0);
        chk("mid_rst_b", writedata, 32'd0);
        read_reg(5'd9);
        chk("mid_rst_rf", writedata, 32'd0);

`ifdef MC_JAL_EN
        alusrca = 0; alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b00;
        readdata = {6'h03, 26'h000_0100};
        irwrite = 1; pcen = 1;
        step();
        irwrite = 0; pcen = 0;
        regdst = 2'b10; memtoreg = 2'b10; regwrite = 1;
        step();
        regwrite = 0; regdst = '0; memtoreg = '0;
        read_reg(5'd31);
        chk("jal_link", writedata, 32'h44);
        chk("jal_link8", writedata8, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
